// File: rtl/skid_buffer_2.sv
// Two-entry valid/ready elastic buffer: registered in_ready and out_valid break
// the ready path between stages while sustaining one transfer per cycle.
module skid_buffer_2 #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] skid_q;
   logic                  in_fire;
   logic                  out_fire;
   logic                  load_main;
   logic                  main_from_skid;
   logic                  load_skid;

   // State and payload registers; main_q always holds the oldest entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_main) begin
            main_q <= main_from_skid ? skid_q : in_data;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

   // Next state and payload load enables; flush overrides everything
   always_comb begin
      state_d        = ST_EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      in_fire        = in_valid & in_ready;
      out_fire       = out_valid & out_ready;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               load_main = 1'b1;
               state_d   = ST_BUSY;
            end else begin
               state_d   = ST_EMPTY;
            end
         end
         ST_BUSY: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
               state_d   = ST_BUSY;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_d   = ST_FULL;
            end else if (out_fire) begin
               state_d   = ST_EMPTY;
            end else begin
               state_d   = ST_BUSY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               load_main      = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ST_BUSY;
            end else begin
               state_d        = ST_FULL;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      if (flush) begin
         state_d        = ST_EMPTY;
         load_main      = 1'b0;
         main_from_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      in_ready  = (state_q != ST_FULL);
      out_valid = (state_q != ST_EMPTY);
      out_data  = out_valid ? main_q : '0;
      case (state_q)
         ST_BUSY: count = 2'd1;
         ST_FULL: count = 2'd2;
         default: count = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_skid_buffer_2.sv
// Directed and randomized-stall bench for skid_buffer_2.
module tb_skid_buffer_2;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  count;

   int checks;
   int failures;

   skid_buffer_2 #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || count !== 2'd0) begin
         failures++;
         $display("FAIL reset_hold: rdy=%b vld=%b data=%h cnt=%0d required 1 0 0 0", in_ready, out_valid, out_data, count);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || count !== 2'd0) begin
            failures++;
            $display("FAIL reset_idle[%0d]: rdy=%b vld=%b data=%h cnt=%0d required 1 0 0 0", i, in_ready, out_valid, out_data, count);
         end
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hA5A5_0001;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || count !== 2'd1) begin
         failures++;
         $display("FAIL single_out: vld=%b data=%h cnt=%0d required 1 a5a50001 1", out_valid, out_data, count);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL single_drain: vld=%b data=%h cnt=%0d required 0 0 0", out_valid, out_data, count);
      end
   endtask

   task automatic test_fill();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h11;
      step();
      checks++;
      if (count !== 2'd1 || out_data !== 32'h11 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL fill_one: cnt=%0d data=%h rdy=%b required 1 11 1", count, out_data, in_ready);
      end
      in_data = 32'h22;
      step();
      checks++;
      if (count !== 2'd2 || out_data !== 32'h11 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL fill_two: cnt=%0d data=%h rdy=%b required 2 11 0", count, out_data, in_ready);
      end
      in_data = 32'h33;
      step();
      checks++;
      if (count !== 2'd2 || out_data !== 32'h11 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL fill_block: cnt=%0d data=%h rdy=%b required 2 11 0", count, out_data, in_ready);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h22 || count !== 2'd1) begin
         failures++;
         $display("FAIL fill_drain22: vld=%b data=%h cnt=%0d required 1 22 1", out_valid, out_data, count);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h33 || count !== 2'd1) begin
         failures++;
         $display("FAIL fill_drain33: vld=%b data=%h cnt=%0d required 1 33 1", out_valid, out_data, count);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         failures++;
         $display("FAIL fill_empty: vld=%b cnt=%0d required 0 0", out_valid, count);
      end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         step();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'(i) || count !== 2'd1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stream[%0d]: vld=%b data=%h cnt=%0d rdy=%b required 1 %h 1 1", i, out_valid, out_data, count, in_ready, i);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL stream_drain: cnt=%0d vld=%b required 0 0", count, out_valid);
      end
   endtask

   task automatic test_random_stall();
      logic [31:0] q[$];
      logic [31:0] next_val;
      logic [31:0] prev_data;
      logic        prev_stall;
      logic        in_f;
      logic        out_f;
      next_val   = 32'h1000;
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         checks++;
         if (count !== 2'(q.size()) || out_valid !== (q.size() != 0)) begin
            failures++;
            $display("FAIL rand_count[%0d]: cnt=%0d vld=%b required %0d", cyc, count, out_valid, q.size());
         end
         if (q.size() != 0) begin
            checks++;
            if (out_data !== q[0]) begin
               failures++;
               $display("FAIL rand_order[%0d]: data=%h required %h", cyc, out_data, q[0]);
            end
         end
         if (prev_stall) begin
            checks++;
            if (out_data !== prev_data || out_valid !== 1'b1) begin
               failures++;
               $display("FAIL rand_stall[%0d]: data=%h vld=%b required %h 1", cyc, out_data, out_valid, prev_data);
            end
         end
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 1) == 1);
         in_data   = next_val;
         in_f       = in_valid && (q.size() < 2);
         out_f      = out_ready && (q.size() != 0);
         prev_stall = (q.size() != 0) && !out_ready;
         prev_data  = (q.size() != 0) ? q[0] : 32'h0;
         step();
         if (out_f) void'(q.pop_front());
         if (in_f) begin
            q.push_back(next_val);
            next_val = next_val + 32'd1;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (q.size() != 0) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== q[0]) begin
            failures++;
            $display("FAIL rand_drain: vld=%b data=%h required 1 %h", out_valid, out_data, q[0]);
         end
         void'(q.pop_front());
         step();
      end
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rand_final: cnt=%0d vld=%b required 0 0", count, out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA1;
      step();
      in_data = 32'hA2;
      step();
      checks++;
      if (count !== 2'd2) begin
         failures++;
         $display("FAIL flush_prefill: cnt=%0d required 2", count);
      end
      flush   = 1'b1;
      in_data = 32'h77;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL flush_clear: cnt=%0d vld=%b data=%h required 0 0 0", count, out_valid, out_data);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || out_data === 32'h77) begin
            failures++;
            $display("FAIL flush_leak[%0d]: vld=%b data=%h required 0 0", i, out_valid, out_data);
         end
      end
      // Flush together with an out_fire from BUSY
      in_valid = 1'b1;
      in_data  = 32'h55;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_data !== 32'h55 || count !== 2'd1) begin
         failures++;
         $display("FAIL flush_refill: data=%h cnt=%0d required 55 1", out_data, count);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h66;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_busy: cnt=%0d vld=%b required 0 0", count, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hBEEF;
      step();
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre: cnt=%0d vld=%b required 1 1", count, out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_async: vld=%b cnt=%0d rdy=%b data=%h required 0 0 1 0", out_valid, count, in_ready, out_data);
      end
      #1;
      rst_n = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         failures++;
         $display("FAIL rstmid_after: vld=%b cnt=%0d required 0 0", out_valid, count);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_streaming();
      test_random_stall();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
